// File: rtl/isr_pkg.sv
// Shared definitions for the interrupt controller: cause indices, widths,
// the repeat mask and the FSM state encoding.
package isr_pkg;

    localparam int NCAUSE = 23;
    localparam int NNMI   = 6;
    localparam int NEV    = 16;
    localparam int NINT   = 6;

    // Causes whose faulting instruction is re-executed after the handler
    // (the two page-fault causes).
    localparam logic [NCAUSE-1:0] REPEAT_MASK = 23'h000018;

    localparam int C_RESET = 0;
    localparam int C_ILL   = 1;
    localparam int C_MAL   = 2;
    localparam int C_PFF   = 3;
    localparam int C_PFLS  = 4;
    localparam int C_TRAP  = 5;
    localparam int C_OVF   = 6;
    localparam int C_EV0   = 7;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_ISR   = 2'd2,
        S_FLUSH = 2'd3
    } isr_state_t;

endpackage

// File: rtl/isr_ctrl_prio_enc.sv
// Lowest-set-bit encoder for the masked cause vector: bit 0 has the
// highest priority. Purely combinational.
module prio_enc
    import isr_pkg::*;
(
    input  logic [NCAUSE-1:0] i_vec,
    output logic [4:0]        o_idx,
    output logic              o_vld
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx = 5'd0;
        o_vld = 1'b0;
        for (int i = NCAUSE - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = 5'(i);
                o_vld = 1'b1;
            end else begin
                o_idx = o_idx;
                o_vld = o_vld;
            end
        end
    end

endmodule

// File: rtl/isr_ctrl.sv
// Interrupt controller: latches external events, masks causes with the
// status register, selects the highest-priority cause and produces the
// registered jisr/mca/rpt/il set for the SPR file, tracking ISR occupancy
// until eret.
module isr_ctrl
    import isr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NINT-1:0]   ca_int,
    input  logic [NEV-1:0]    ev,
    input  logic [NCAUSE-1:0] sr,
    input  logic              ue,
    input  logic              eret,
    output logic              jisr,
    output logic [NCAUSE-1:0] mca,
    output logic              rpt,
    output logic [4:0]        il,
    output logic [NEV-1:0]    pend,
    output logic              in_isr
);

    isr_state_t        r_state;
    isr_state_t        w_state_nxt;
    logic              r_jisr;
    logic [NCAUSE-1:0] r_mca;
    logic              r_rpt;
    logic [4:0]        r_il;
    logic [NEV-1:0]    r_pend;
    logic              r_in_isr;

    logic              w_jisr_nxt;
    logic [NCAUSE-1:0] w_mca_nxt;
    logic              w_rpt_nxt;
    logic [4:0]        w_il_nxt;
    logic [NEV-1:0]    w_pend_nxt;
    logic              w_in_isr_nxt;

    logic [NCAUSE-1:0] w_ca;
    logic [NCAUSE-1:0] w_mask;
    logic [NCAUSE-1:0] w_mca_c;
    logic [4:0]        w_il;
    logic              w_vld;
    logic              w_take;
    logic [NEV-1:0]    w_pend_clr;

    // Internal causes only count at an instruction boundary. Maskable causes
    // are only enabled in RUN; the low non-maskable bits are always enabled.
    assign w_ca    = {r_pend, ca_int & {NINT{ue}}, 1'b0};
    assign w_mask  = (sr & {{(NCAUSE-NNMI){r_state == S_RUN}}, {NNMI{1'b0}}})
                   | {{(NCAUSE-NNMI){1'b0}}, {NNMI{1'b1}}};
    assign w_mca_c = w_ca & w_mask;

    prio_enc u_prio_enc (
        .i_vec (w_mca_c),
        .o_idx (w_il),
        .o_vld (w_vld)
    );

    // In ISR the mask leaves only non-maskable bits, so w_vld alone decides
    // a nested jump there as well as a normal one in RUN.
    assign w_take     = ue && w_vld && ((r_state == S_RUN) || (r_state == S_ISR));
    assign w_pend_clr = w_take ? w_mca_c[C_EV0 +: NEV] : {NEV{1'b0}};
    assign w_pend_nxt = (r_pend & ~w_pend_clr) | ev;

    // State and output registers; reset forces BOOT with all outputs low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_BOOT;
            r_jisr   <= 1'b0;
            r_mca    <= {NCAUSE{1'b0}};
            r_rpt    <= 1'b0;
            r_il     <= 5'd0;
            r_pend   <= {NEV{1'b0}};
            r_in_isr <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_jisr   <= w_jisr_nxt;
            r_mca    <= w_mca_nxt;
            r_rpt    <= w_rpt_nxt;
            r_il     <= w_il_nxt;
            r_pend   <= w_pend_nxt;
            r_in_isr <= w_in_isr_nxt;
        end
    end

    // Next-state selection; a cause taken in ISR wins over a simultaneous eret.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_FLUSH;
            S_RUN: begin
                if (w_take) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_FLUSH: w_state_nxt = S_ISR;
            S_ISR: begin
                if (w_take) begin
                    w_state_nxt = S_FLUSH;
                end else if (ue && eret) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_ISR;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // Next values of the registered outputs; all jump fields are zero
    // unless a jisr pulse is being registered.
    always_comb begin
        w_jisr_nxt   = 1'b0;
        w_mca_nxt    = {NCAUSE{1'b0}};
        w_rpt_nxt    = 1'b0;
        w_il_nxt     = 5'd0;
        w_in_isr_nxt = r_in_isr;
        case (r_state)
            S_BOOT: begin
                w_jisr_nxt   = 1'b1;
                w_mca_nxt    = 23'h000001;
                w_in_isr_nxt = 1'b1;
            end
            S_RUN, S_ISR: begin
                if (w_take) begin
                    w_jisr_nxt   = 1'b1;
                    w_mca_nxt    = w_mca_c;
                    w_il_nxt     = w_il;
                    w_rpt_nxt    = REPEAT_MASK[w_il];
                    w_in_isr_nxt = 1'b1;
                end else if ((r_state == S_ISR) && ue && eret) begin
                    w_in_isr_nxt = 1'b0;
                end else begin
                    w_in_isr_nxt = (r_state == S_ISR);
                end
            end
            S_FLUSH: w_in_isr_nxt = 1'b1;
            default: w_in_isr_nxt = 1'b0;
        endcase
    end

    assign jisr   = r_jisr;
    assign mca    = r_mca;
    assign rpt    = r_rpt;
    assign il     = r_il;
    assign pend   = r_pend;
    assign in_isr = r_in_isr;

endmodule

// File: tb/tb_isr_ctrl.sv
// Scoreboard bench for isr_ctrl: directed sequence plus random stimulus,
// expected observations from a behavioural model pushed into a queue and
// compared by an independent monitor one step after each clock edge.
module tb_isr_ctrl;

    typedef struct packed {
        logic        jisr;
        logic [22:0] mca;
        logic        rpt;
        logic [4:0]  il;
        logic [15:0] pend;
        logic        in_isr;
    } obs_t;

    logic        clk;
    logic        reset;
    logic [5:0]  ca_int;
    logic [15:0] ev;
    logic [22:0] sr;
    logic        ue;
    logic        eret;
    logic        jisr;
    logic [22:0] mca;
    logic        rpt;
    logic [4:0]  il;
    logic [15:0] pend;
    logic        in_isr;

    int n_vec;
    int n_err;
    obs_t exp_q[$];

    // Model state: booting, just jumped (handler entry cycle), inside handler.
    bit          m_boot;
    bit          m_flush;
    bit          m_in_isr;
    logic [15:0] m_pend;

    isr_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .ca_int (ca_int),
        .ev     (ev),
        .sr     (sr),
        .ue     (ue),
        .eret   (eret),
        .jisr   (jisr),
        .mca    (mca),
        .rpt    (rpt),
        .il     (il),
        .pend   (pend),
        .in_isr (in_isr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference behaviour for one clock edge given the inputs of this cycle.
    function automatic obs_t model_step(bit r, logic [5:0] ci, logic [15:0] e,
                                        logic [22:0] s, bit u, bit er);
        obs_t o;
        logic [22:0] causes;
        o = '0;
        if (r) begin
            m_boot = 1; m_flush = 0; m_in_isr = 0; m_pend = 16'h0;
        end else if (m_boot) begin
            o.jisr = 1'b1; o.mca = 23'h1;
            m_boot = 0; m_flush = 1; m_in_isr = 1;
            m_pend = m_pend | e;
        end else if (m_flush) begin
            m_flush = 0;
            m_pend = m_pend | e;
        end else begin
            causes = '0;
            for (int k = 1; k <= 6; k++)
                if (u && ci[k-1] && (k < 6 || (!m_in_isr && s[k]))) causes[k] = 1'b1;
            for (int k = 7; k < 23; k++)
                if (u && m_pend[k-7] && !m_in_isr && s[k]) causes[k] = 1'b1;
            if (causes != 0) begin
                int lo;
                lo = 0;
                for (int k = 22; k >= 0; k--) if (causes[k]) lo = k;
                o.jisr = 1'b1; o.mca = causes; o.il = 5'(lo);
                o.rpt = (lo == 3 || lo == 4);
                m_flush = 1; m_in_isr = 1;
                m_pend = (m_pend & ~causes[22:7]) | e;
            end else begin
                if (m_in_isr && u && er) m_in_isr = 0;
                m_pend = m_pend | e;
            end
        end
        o.pend = m_pend;
        o.in_isr = m_in_isr;
        return o;
    endfunction

    task automatic step(bit r, logic [5:0] ci, logic [15:0] e, logic [22:0] s,
                        bit u, bit er);
        @(negedge clk);
        reset = r; ca_int = ci; ev = e; sr = s; ue = u; eret = er;
        exp_q.push_back(model_step(r, ci, e, s, u, er));
        @(posedge clk);
        #2;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: compare every registered observation against the scoreboard.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{jisr, mca, rpt, il, pend, in_isr};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL sb_obs t=%0t: got jisr=%b mca=%h rpt=%b il=%0d pend=%h in_isr=%b, required jisr=%b mca=%h rpt=%b il=%0d pend=%h in_isr=%b",
                             $time, a.jisr, a.mca, a.rpt, a.il, a.pend, a.in_isr,
                             e.jisr, e.mca, e.rpt, e.il, e.pend, e.in_isr);
                end
            end
        end
    end

    initial begin
        logic [22:0] ones;
        n_vec = 0; n_err = 0;
        ones = 23'h7FFFFF;
        reset = 1'b1; ca_int = 6'h0; ev = 16'h0; sr = 23'h0; ue = 1'b0; eret = 1'b0;
        m_boot = 1; m_flush = 0; m_in_isr = 0; m_pend = 16'h0;

        // Reset sequence
        step(1, 6'h0, 16'h0, 23'h0, 0, 0);
        step(1, 6'h0, 16'h0, 23'h0, 0, 0);
        chk("rst_jisr", 32'(jisr), 32'h0);
        chk("rst_in_isr", 32'(in_isr), 32'h0);
        step(0, 6'h0, 16'h0, 23'h0, 0, 0);
        chk("boot_jisr", 32'(jisr), 32'h1);
        chk("boot_mca", 32'(mca), 32'h1);
        chk("boot_il", 32'(il), 32'h0);
        chk("boot_rpt", 32'(rpt), 32'h0);
        step(0, 6'h0, 16'h0, 23'h0, 0, 0);
        chk("flush_jisr", 32'(jisr), 32'h0);
        chk("flush_in_isr", 32'(in_isr), 32'h1);

        // Masked external event, then unmasked
        step(0, 6'h0, 16'h0, 23'h0, 1, 1);
        chk("eret_in_isr", 32'(in_isr), 32'h0);
        step(0, 6'h0, 16'h0004, 23'h0, 1, 0);
        step(0, 6'h0, 16'h0, 23'h0, 1, 0);
        chk("masked_jisr", 32'(jisr), 32'h0);
        chk("masked_pend", 32'(pend), 32'h4);
        step(0, 6'h0, 16'h0, 23'h000200, 1, 0);
        chk("ev_jisr", 32'(jisr), 32'h1);
        chk("ev_mca", 32'(mca), 32'h200);
        chk("ev_il", 32'(il), 32'd9);
        chk("ev_pend", 32'(pend), 32'h0);
        step(0, 6'h0, 16'h0, 23'h0, 1, 1);
        step(0, 6'h0, 16'h0, 23'h0, 1, 1);

        // Page fault repeat
        step(0, 6'b001000, 16'h0, 23'h0, 1, 0);
        chk("pf_mca", 32'(mca), 32'h10);
        chk("pf_il", 32'(il), 32'd4);
        chk("pf_rpt", 32'(rpt), 32'h1);
        step(0, 6'h0, 16'h0, 23'h0, 0, 0);
        step(0, 6'h0, 16'h0, 23'h0, 1, 1);

        // Priority: ill beats ovf
        step(0, 6'b100001, 16'h0, ones, 1, 0);
        chk("prio_mca", 32'(mca), 32'h42);
        chk("prio_il", 32'(il), 32'd1);
        chk("prio_rpt", 32'(rpt), 32'h0);
        step(0, 6'h0, 16'h0, ones, 0, 0);

        // Event held off while in the handler
        step(0, 6'h0, 16'h0001, ones, 1, 0);
        step(0, 6'h0, 16'h0, ones, 1, 0);
        chk("isr_mask_jisr", 32'(jisr), 32'h0);
        chk("isr_mask_pend", 32'(pend), 32'h1);
        step(0, 6'h0, 16'h0, ones, 1, 1);
        chk("isr_eret", 32'(in_isr), 32'h0);
        step(0, 6'h0, 16'h0, ones, 1, 0);
        chk("ev0_mca", 32'(mca), 32'h80);
        chk("ev0_il", 32'(il), 32'd7);
        step(0, 6'h0, 16'h0, ones, 0, 0);

        // Cause beats eret, then reset during the pulse
        step(0, 6'b010000, 16'h0, ones, 1, 1);
        chk("nest_mca", 32'(mca), 32'h20);
        chk("nest_in_isr", 32'(in_isr), 32'h1);
        step(1, 6'h0, 16'h0, ones, 1, 0);
        chk("midrst_jisr", 32'(jisr), 32'h0);
        chk("midrst_mca", 32'(mca), 32'h0);
        chk("midrst_in_isr", 32'(in_isr), 32'h0);
        step(0, 6'h0, 16'h0, ones, 0, 0);
        chk("reboot_mca", 32'(mca), 32'h1);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            bit r, u, er;
            logic [5:0] ci;
            logic [15:0] e;
            logic [22:0] s;
            r  = ($urandom_range(0, 199) == 0);
            u  = ($urandom_range(0, 9) < 6);
            er = ($urandom_range(0, 3) == 0);
            ci = 6'h0;
            for (int b = 0; b < 6; b++) ci[b] = ($urandom_range(0, 11) == 0);
            e  = ($urandom_range(0, 5) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
            s  = 23'($urandom);
            step(r, ci, e, s, u, er);
        end

        repeat (2) @(posedge clk);
        #3;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
